// File: rtl/cpu_datapath_gen.sv
// cpu_datapath_gen: parametrised multicycle CPU datapath.
//
// Holds the register file, PC/IR/MDR/operand/ALU-out registers, an ALU with N/Z/C/V flags and a
// request/acknowledge memory port that tolerates any number of wait states. The multicycle
// controller drives the select/enable inputs and sequences on mem_done.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   alu_1_sel, alu_2_sel       ALU A (pc/opA) and B (opB/imm_s/imm_l/1) selects
//   alu_op                     ALU operation
//   reg_in_sel, reg_w_sel      RF write data select and write index select (rA / link)
//   pc_sel, addr_sel           PC next-value select, memory address select
//   opA_wr .. rf_wr            register write enables
//   mem_rd, mem_wr, load_ir    start read / write transaction, read destination (IR / MDR)
//   mem_req, mem_we            bus request and its write qualifier
//   mem_addr, mem_wdata        latched transaction address and write data
//   mem_rdata, mem_ack         read data and transaction acknowledge
//   mem_busy, mem_done         transaction outstanding, one-cycle completion pulse
//   instr                      ir[4:0] opcode to the controller
//   flag_n/z/c/v               status flags
//
// Build option: define CPU_DP_CV_FLAGS_EN to include the carry/overflow logic; without it
// flag_c and flag_v are tied to 0.

module cpu_datapath_gen #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_1_sel,
  input  logic [1:0]        alu_2_sel,
  input  logic [2:0]        alu_op,
  input  logic [2:0]        reg_in_sel,
  input  logic              reg_w_sel,
  input  logic              pc_sel,
  input  logic              addr_sel,
  input  logic              opA_wr,
  input  logic              opB_wr,
  input  logic              alu_out_wr,
  input  logic              pc_wr,
  input  logic              flag_wr,
  input  logic              rf_wr,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic              load_ir,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_busy,
  output logic              mem_done,
  output logic [4:0]        instr,
  output logic              flag_n,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_v
);

  localparam int unsigned NReg  = 2 ** REG_AW;
  localparam int unsigned ImmSW = DATA_W - 5 - 2 * REG_AW;
  localparam int unsigned ImmLW = DATA_W - 5 - REG_AW;

  typedef enum logic {StIdle, StBusy} mem_state_e;

  // Architectural registers
  logic [DATA_W-1:0] pc_q, ir_q, mdr_q, opa_q, opb_q, alu_out_q;
  logic [DATA_W-1:0] rf_q [NReg];
  logic              flag_n_q, flag_z_q;

  // Memory port state
  mem_state_e        state_q, state_d;
  logic [DATA_W-1:0] mem_addr_q, mem_wdata_q;
  logic              mem_we_q, dest_ir_q, mem_done_q;
  logic              txn_start, txn_complete;

  // IR field decode
  logic [REG_AW-1:0] ra, rb, rf_widx;
  logic [DATA_W-1:0] imm_s, imm_l;

  assign instr = ir_q[4:0];
  assign ra    = ir_q[4+REG_AW:5];
  assign rb    = ir_q[4+2*REG_AW:5+REG_AW];
  assign imm_s = {{(DATA_W - ImmSW){ir_q[DATA_W-1]}}, ir_q[DATA_W-1:DATA_W-ImmSW]};
  assign imm_l = {{(DATA_W - ImmLW){ir_q[DATA_W-1]}}, ir_q[DATA_W-1:DATA_W-ImmLW]};

  // Register file: asynchronous read, so same-cycle reads see the pre-write value
  logic [DATA_W-1:0] rf_a, rf_b, rf_wdata;

  assign rf_a    = rf_q[ra];
  assign rf_b    = rf_q[rb];
  assign rf_widx = reg_w_sel ? {REG_AW{1'b1}} : ra;

  always_comb begin
    rf_wdata = '0;
    case (reg_in_sel)
      3'd0:    rf_wdata = alu_out_q;
      3'd1:    rf_wdata = mdr_q;
      3'd2:    rf_wdata = opb_q;
      3'd3:    rf_wdata = imm_l;
      3'd4:    rf_wdata = opa_q;
      3'd5:    rf_wdata = pc_q;
      default: rf_wdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NReg; i++) begin
        rf_q[i] <= '0;
      end
    end else if (rf_wr) begin
      rf_q[rf_widx] <= rf_wdata;
    end
  end

  // ALU
  logic [DATA_W-1:0] alu_a, alu_b, alu_res;

  assign alu_a = alu_1_sel ? opa_q : pc_q;

  always_comb begin
    alu_b = '0;
    case (alu_2_sel)
      2'd0:    alu_b = opb_q;
      2'd1:    alu_b = imm_s;
      2'd2:    alu_b = imm_l;
      default: alu_b = DATA_W'(1);
    endcase
  end

  always_comb begin
    alu_res = '0;
    case (alu_op)
      3'd0:    alu_res = alu_a + alu_b;
      3'd1:    alu_res = alu_a - alu_b;
      3'd2:    alu_res = alu_a & alu_b;
      3'd3:    alu_res = alu_a | alu_b;
      3'd4:    alu_res = alu_a ^ alu_b;
      3'd5:    alu_res = {alu_a[DATA_W-2:0], 1'b0};
      3'd6:    alu_res = {1'b0, alu_a[DATA_W-1:1]};
      default: alu_res = alu_b;
    endcase
  end

`ifdef CPU_DP_CV_FLAGS_EN
  logic alu_c, alu_v, flag_c_q, flag_v_q;

  // Carry of an add shows up as a wrapped (smaller) sum; borrow of a subtract is a < b.
  always_comb begin
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (alu_op)
      3'd0: begin
        alu_c = alu_res < alu_a;
        alu_v = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) && (alu_res[DATA_W-1] != alu_a[DATA_W-1]);
      end
      3'd1: begin
        alu_c = alu_a < alu_b;
        alu_v = (alu_a[DATA_W-1] != alu_b[DATA_W-1]) && (alu_res[DATA_W-1] != alu_a[DATA_W-1]);
      end
      3'd5:    alu_c = alu_a[DATA_W-1];
      3'd6:    alu_c = alu_a[0];
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flag_c_q <= 1'b0;
      flag_v_q <= 1'b0;
    end else if (flag_wr) begin
      flag_c_q <= alu_c;
      flag_v_q <= alu_v;
    end
  end

  assign flag_c = flag_c_q;
  assign flag_v = flag_v_q;
`else
  assign flag_c = 1'b0;
  assign flag_v = 1'b0;
`endif

  assign flag_n = flag_n_q;
  assign flag_z = flag_z_q;

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= '0;
      ir_q      <= '0;
      mdr_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      alu_out_q <= '0;
      flag_n_q  <= 1'b0;
      flag_z_q  <= 1'b0;
    end else begin
      if (pc_wr)      pc_q      <= pc_sel ? opa_q : alu_res;
      if (opA_wr)     opa_q     <= rf_a;
      if (opB_wr)     opb_q     <= rf_b;
      if (alu_out_wr) alu_out_q <= alu_res;
      if (flag_wr) begin
        flag_n_q <= alu_res[DATA_W-1];
        flag_z_q <= (alu_res == '0);
      end
      if (txn_complete && !mem_we_q) begin
        if (dest_ir_q) ir_q  <= mem_rdata;
        else           mdr_q <= mem_rdata;
      end
    end
  end

  // Memory transaction FSM
  always_comb begin
    state_d      = state_q;
    txn_start    = 1'b0;
    txn_complete = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mem_rd || mem_wr) begin
          state_d   = StBusy;
          txn_start = 1'b1;
        end
      end
      StBusy: begin
        if (mem_ack) begin
          state_d      = StIdle;
          txn_complete = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      dest_ir_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_done_q <= txn_complete;
      // Address/data/direction are frozen for the whole transaction; a write wins over a read.
      if (txn_start) begin
        mem_addr_q  <= addr_sel ? opb_q : pc_q;
        mem_wdata_q <= opa_q;
        mem_we_q    <= mem_wr;
        dest_ir_q   <= load_ir;
      end
    end
  end

  assign mem_req   = (state_q == StBusy);
  assign mem_busy  = (state_q == StBusy);
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_done  = mem_done_q;

endmodule

// File: tb/tb_cpu_datapath_gen.sv
// Self-checking bench for cpu_datapath_gen. Two instances (16-bit/8 regs and 32-bit/16 regs)
// share all control inputs; register contents and ALU results are observed through the
// write-data/address of memory transactions, compared against a scoreboard of expectations.

module tb_cpu_datapath_gen;

`ifdef CPU_DP_CV_FLAGS_EN
  localparam bit CvEn = 1'b1;
`else
  localparam bit CvEn = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        alu_1_sel, reg_w_sel, pc_sel, addr_sel;
  logic [1:0]  alu_2_sel;
  logic [2:0]  alu_op, reg_in_sel;
  logic        opA_wr, opB_wr, alu_out_wr, pc_wr, flag_wr, rf_wr;
  logic        mem_rd, mem_wr, load_ir, mem_ack;
  logic [15:0] rdata16;
  logic [31:0] rdata32;

  logic        req16, we16, busy16, done16, fn16, fz16, fc16, fv16;
  logic [15:0] addr16, wdata16;
  logic [4:0]  instr16;
  logic        req32, we32, busy32, done32, fn32, fz32, fc32, fv32;
  logic [31:0] addr32, wdata32;
  logic [4:0]  instr32;

  cpu_datapath_gen #(.DATA_W(16), .REG_AW(3)) u_dut16 (
    .clk(clk), .reset(reset), .alu_1_sel(alu_1_sel), .alu_2_sel(alu_2_sel), .alu_op(alu_op),
    .reg_in_sel(reg_in_sel), .reg_w_sel(reg_w_sel), .pc_sel(pc_sel), .addr_sel(addr_sel),
    .opA_wr(opA_wr), .opB_wr(opB_wr), .alu_out_wr(alu_out_wr), .pc_wr(pc_wr),
    .flag_wr(flag_wr), .rf_wr(rf_wr), .mem_rd(mem_rd), .mem_wr(mem_wr), .load_ir(load_ir),
    .mem_req(req16), .mem_we(we16), .mem_addr(addr16), .mem_wdata(wdata16),
    .mem_rdata(rdata16), .mem_ack(mem_ack), .mem_busy(busy16), .mem_done(done16),
    .instr(instr16), .flag_n(fn16), .flag_z(fz16), .flag_c(fc16), .flag_v(fv16)
  );

  cpu_datapath_gen #(.DATA_W(32), .REG_AW(4)) u_dut32 (
    .clk(clk), .reset(reset), .alu_1_sel(alu_1_sel), .alu_2_sel(alu_2_sel), .alu_op(alu_op),
    .reg_in_sel(reg_in_sel), .reg_w_sel(reg_w_sel), .pc_sel(pc_sel), .addr_sel(addr_sel),
    .opA_wr(opA_wr), .opB_wr(opB_wr), .alu_out_wr(alu_out_wr), .pc_wr(pc_wr),
    .flag_wr(flag_wr), .rf_wr(rf_wr), .mem_rd(mem_rd), .mem_wr(mem_wr), .load_ir(load_ir),
    .mem_req(req32), .mem_we(we32), .mem_addr(addr32), .mem_wdata(wdata32),
    .mem_rdata(rdata32), .mem_ack(mem_ack), .mem_busy(busy32), .mem_done(done32),
    .instr(instr32), .flag_n(fn32), .flag_z(fz32), .flag_c(fc32), .flag_v(fv32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t sb16[$];
  txn_t sb32[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect16(input logic we, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d;
    sb16.push_back(t);
  endtask

  task automatic expect32(input logic we, input logic [31:0] a, input logic [31:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d;
    sb32.push_back(t);
  endtask

  task automatic check_flags16(input string tag, input logic n, input logic z, input logic c,
                               input logic v);
    check_eq({tag, "_n"}, 32'(fn16), 32'(n));
    check_eq({tag, "_z"}, 32'(fz16), 32'(z));
    check_eq({tag, "_c"}, 32'(fc16), 32'(c));
    check_eq({tag, "_v"}, 32'(fv16), 32'(v));
  endtask

  // One memory transaction with n cycles of mem_req before the acking edge.
  task automatic mem_txn(input logic wr, input logic rd, input logic asel, input logic ir_dest,
                         input logic [31:0] d16, input logic [31:0] d32, input int n,
                         input bit rd_in_busy, input bit pc_inc);
    txn_t e16, e32;
    bit   have16, have32;
    int   req_cycles;
    mem_wr = wr; mem_rd = rd; addr_sel = asel; load_ir = ir_dest;
    if (pc_inc) begin
      pc_wr = 1'b1; pc_sel = 1'b0; alu_1_sel = 1'b0; alu_2_sel = 2'd3; alu_op = 3'd0;
    end
    step();
    mem_wr = 1'b0; mem_rd = 1'b0; load_ir = 1'b0; pc_wr = 1'b0;
    have16 = sb16.size() > 0;
    have32 = sb32.size() > 0;
    if (have16) begin
      e16 = sb16.pop_front();
      check_eq("txn_we16", 32'(we16), 32'(e16.we));
      check_eq("txn_addr16", 32'(addr16), e16.addr);
      check_eq("txn_wdata16", 32'(wdata16), e16.wdata);
    end
    if (have32) begin
      e32 = sb32.pop_front();
      check_eq("txn_we32", 32'(we32), 32'(e32.we));
      check_eq("txn_addr32", addr32, e32.addr);
      check_eq("txn_wdata32", wdata32, e32.wdata);
    end
    req_cycles = 0;
    for (int i = 0; i < n; i++) begin
      if (req16 && busy16) req_cycles++;
      check_eq("busy_no_done16", 32'(done16), 32'd0);
      if (have16) check_eq("addr_stable16", 32'(addr16), e16.addr);
      if (i == n - 1) begin
        mem_ack = 1'b1; rdata16 = d16[15:0]; rdata32 = d32;
      end
      if (rd_in_busy && i == 0) mem_rd = 1'b1;
      step();
      mem_ack = 1'b0; mem_rd = 1'b0;
    end
    check_eq("req_cycles16", 32'(req_cycles), 32'(n));
    check_eq("done16", 32'(done16), 32'd1);
    check_eq("req_drop16", 32'(req16), 32'd0);
    if (have32) check_eq("done32", 32'(done32), 32'd1);
  endtask

  task automatic fetch(input logic [31:0] w16, input logic [31:0] w32);
    mem_txn(1'b0, 1'b1, 1'b0, 1'b1, w16, w32, 1, 1'b0, 1'b0);
  endtask

  task automatic store(input int n);
    mem_txn(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, n, 1'b0, 1'b0);
  endtask

  task automatic rf_write(input logic [2:0] in_sel, input logic w_sel);
    reg_in_sel = in_sel; reg_w_sel = w_sel; rf_wr = 1'b1;
    step();
    rf_wr = 1'b0; reg_w_sel = 1'b0;
  endtask

  task automatic load_ops();
    opA_wr = 1'b1; opB_wr = 1'b1;
    step();
    opA_wr = 1'b0; opB_wr = 1'b0;
  endtask

  task automatic alu_exec(input logic a1, input logic [1:0] a2, input logic [2:0] op);
    alu_1_sel = a1; alu_2_sel = a2; alu_op = op; alu_out_wr = 1'b1; flag_wr = 1'b1;
    step();
    alu_out_wr = 1'b0; flag_wr = 1'b0;
  endtask

  task automatic pc_step();
    pc_wr = 1'b1; pc_sel = 1'b0; alu_1_sel = 1'b0; alu_2_sel = 2'd3; alu_op = 3'd0;
    step();
    pc_wr = 1'b0;
  endtask

  // IR with rA = idx, then MDR = val, then RF[rA] = MDR (both instances).
  task automatic set_reg(input int idx, input logic [31:0] val);
    fetch(32'(idx) << 5, 32'(idx) << 5);
    mem_txn(1'b0, 1'b1, 1'b0, 1'b0, val, val, 1, 1'b0, 1'b0);
    rf_write(3'd1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1;
    alu_1_sel = 1'b0; alu_2_sel = 2'd0; alu_op = 3'd0; reg_in_sel = 3'd0; reg_w_sel = 1'b0;
    pc_sel = 1'b0; addr_sel = 1'b0; opA_wr = 1'b0; opB_wr = 1'b0; alu_out_wr = 1'b0;
    pc_wr = 1'b0; flag_wr = 1'b0; rf_wr = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    load_ir = 1'b0; mem_ack = 1'b0; rdata16 = '0; rdata32 = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req", 32'(req16), 32'd0);
    check_eq("rst_we", 32'(we16), 32'd0);
    check_eq("rst_busy", 32'(busy16), 32'd0);
    check_eq("rst_done", 32'(done16), 32'd0);
    check_eq("rst_addr", 32'(addr16), 32'd0);
    check_eq("rst_wdata", 32'(wdata16), 32'd0);
    check_eq("rst_instr", 32'(instr16), 32'd0);
    check_flags16("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("rst_addr32", addr32, 32'd0);
    reset = 1'b0;
    step();

    // Fetch with three wait states
    expect16(1'b0, 32'h0, 32'h0);
    mem_txn(1'b0, 1'b1, 1'b0, 1'b1, 32'h1234, 32'h1234, 3, 1'b0, 1'b0);
    check_eq("fetch_instr", 32'(instr16), 32'h14);
    step();
    check_eq("fetch_done_pulse", 32'(done16), 32'd0);

    // ADD 0x7FFF + 1
    set_reg(1, 32'h7FFF);
    set_reg(2, 32'h0001);
    fetch(32'h0220, 32'h0220);
    load_ops();
    alu_exec(1'b1, 2'd0, 3'd0);
    check_flags16("add", 1'b1, 1'b0, 1'b0, CvEn);
    rf_write(3'd0, 1'b0);
    load_ops();
    expect16(1'b1, 32'h0001, 32'h8000);
    store(2);

    // SUB 3 - 5, then 5 - 5
    set_reg(3, 32'h0003);
    set_reg(4, 32'h0005);
    fetch(32'h0460, 32'h0460);
    load_ops();
    alu_exec(1'b1, 2'd0, 3'd1);
    check_flags16("sub_borrow", 1'b1, 1'b0, CvEn, 1'b0);
    rf_write(3'd0, 1'b0);
    load_ops();
    expect16(1'b1, 32'h0005, 32'hFFFE);
    store(1);
    fetch(32'h0480, 32'h0480);
    load_ops();
    alu_exec(1'b1, 2'd0, 3'd1);
    check_flags16("sub_zero", 1'b0, 1'b1, 1'b0, 1'b0);

    // Shifts: SHL1 of 0x8000 drops the MSB; SHR1 of 0xFFFE is logical
    fetch(32'h0020, 32'h0020);
    load_ops();
    alu_exec(1'b1, 2'd0, 3'd5);
    check_flags16("shl", 1'b0, 1'b1, CvEn, 1'b0);
    fetch(32'h0060, 32'h0060);
    load_ops();
    alu_exec(1'b1, 2'd0, 3'd6);
    check_flags16("shr", 1'b0, 1'b0, 1'b0, 1'b0);
    rf_write(3'd0, 1'b0);
    load_ops();
    expect16(1'b1, 32'h0000, 32'h7FFF);
    store(1);

    // Write wins over a simultaneous read; a read pulse while busy is ignored
    set_reg(5, 32'hBEEF);
    set_reg(6, 32'h0040);
    fetch(32'h06A0, 32'h06A0);
    load_ops();
    expect16(1'b1, 32'h0040, 32'hBEEF);
    mem_txn(1'b1, 1'b1, 1'b1, 1'b1, 32'h5555, 32'h5555, 3, 1'b1, 1'b0);
    check_eq("write_keeps_ir", 32'(instr16), 32'h00);
    step();
    check_eq("busy_rd_ignored", 32'(req16), 32'd0);

    // pc_wr in the request cycle: address uses the old pc; next read back-to-back
    expect16(1'b0, 32'h0000, 32'hBEEF);
    mem_txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h1111, 32'h1111, 1, 1'b0, 1'b1);
    expect16(1'b0, 32'h0001, 32'hBEEF);
    mem_txn(1'b0, 1'b1, 1'b0, 1'b0, 32'h2222, 32'h2222, 1, 1'b0, 1'b0);

    // Reset during an outstanding read
    mem_rd = 1'b1; load_ir = 1'b0; addr_sel = 1'b0;
    step();
    mem_rd = 1'b0;
    check_eq("midrst_busy", 32'(req16), 32'd1);
    rdata16 = 16'hDEAD; rdata32 = 32'hDEAD;
    #2 reset = 1'b1;
    #1;
    check_eq("midrst_req", 32'(req16), 32'd0);
    check_eq("midrst_busy_off", 32'(busy16), 32'd0);
    mem_ack = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("midrst_no_done", 32'(done16), 32'd0);
    end
    mem_ack = 1'b0;
    rf_write(3'd1, 1'b0);
    load_ops();
    expect16(1'b1, 32'h0000, 32'h0000);
    store(1);

    // Wide instance: link write of pc, imm_l / imm_s sign extension
    pc_step();
    pc_step();
    rf_write(3'd5, 1'b1);
    fetch(32'h01E0, 32'h01E0);
    load_ops();
    expect16(1'b1, 32'h0, 32'h2);
    expect32(1'b1, 32'h0, 32'h2);
    store(1);
    fetch(32'h0060, 32'h8000_0060);
    rf_write(3'd3, 1'b0);
    load_ops();
    expect16(1'b1, 32'h0, 32'h0);
    expect32(1'b1, 32'h0, 32'hFFC0_0000);
    store(2);
    alu_exec(1'b0, 2'd1, 3'd7);
    check_eq("imm_s_n32", 32'(fn32), 32'd1);
    check_eq("imm_s_z32", 32'(fz32), 32'd0);
    check_eq("imm_s_z16", 32'(fz16), 32'd1);
    rf_write(3'd0, 1'b0);
    load_ops();
    expect16(1'b1, 32'h0, 32'h0);
    expect32(1'b1, 32'h0, 32'hFFFC_0000);
    store(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
